// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, adder latency and the issue FSM state encoding.
package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Register stages inside the 32-bit pipelined prefix adder.
  localparam int ADD_LATENCY = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational flag derivation from an adder result; reusable by later ALU stages.
module alu_flags (
  input  logic [31:0] sum,
  input  logic        cout,
  input  logic        x31,
  input  logic        y31,
  output logic        carry,
  output logic        zero,
  output logic        neg,
  output logic        ovf
);

  // For subtract the adder sees ~b + 1, so carry = 1 means "no borrow".
  assign carry = cout;
  assign zero  = (sum == 32'd0);
  assign neg   = sum[31];
  // Signed overflow: operands agree in sign but the result does not (y is the effective operand).
  assign ovf   = (x31 == y31) && (sum[31] != x31);

endmodule

// File: rtl/add_issue_ctrl.sv
// Issue/retire sequencer around the pipelined prefix adder: one operation in flight,
// operands held for the full adder depth, tagged result with flags on a valid/ready port.
module add_issue_ctrl
  import alu_pkg::*;
#(
  parameter int LATENCY = ADD_LATENCY,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_cin,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      add_x,
  output logic [31:0]      add_y,
  output logic             add_cin,
  input  logic [31:0]      add_out,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_sum,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_carry,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_ovf
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             accept;
  logic             capture;
  logic             flag_carry;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_ovf;

  // Ready is gated by reset and is the only combinational path (from res_ready).
  assign req_ready = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && res_ready));
  assign accept    = req_valid && req_ready;
  assign capture   = (state_reg == RUN) && (cnt_reg == '0);
  assign res_valid = (state_reg == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DONE can hand straight over to RUN when a request is waiting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (cnt_reg == '0) state_next = DONE;
      DONE: if (res_ready) state_next = req_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand formation on accept, held until the next accept; latency countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_x   <= '0;
      add_y   <= '0;
      add_cin <= 1'b0;
      tag_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      add_x   <= req_a;
      tag_reg <= req_tag;
      cnt_reg <= CNT_W'(LATENCY);
      if (req_op == ALU_OP_SUB) begin
        add_y   <= ~req_b;
        add_cin <= 1'b1;
      end else begin
        add_y   <= req_b;
        add_cin <= req_cin;
      end
    end else if ((state_reg == RUN) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Sign bits come from the held operands, which still match the op in flight.
  alu_flags u_flags (
    .sum   (add_out),
    .cout  (add_cout),
    .x31   (add_x[31]),
    .y31   (add_y[31]),
    .carry (flag_carry),
    .zero  (flag_zero),
    .neg   (flag_neg),
    .ovf   (flag_ovf)
  );

  // Result capture once the adder has settled; held through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_sum   <= '0;
      res_tag   <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (capture) begin
      res_sum   <= add_out;
      res_tag   <= tag_reg;
      res_carry <= flag_carry;
      res_zero  <= flag_zero;
      res_neg   <= flag_neg;
      res_ovf   <= flag_ovf;
    end
  end

endmodule

// File: doc/add_issue_ctrl.md
# add_issue_ctrl

Request/response sequencer that sits directly upstream and downstream of the 32-bit pipelined prefix adder in the ALU. It accepts add/subtract requests over a valid/ready handshake, forms and holds the adder operands (`x`, `y`, `cin`) stable for the adder's full register depth, and counts out the latency. It then captures `out`/`cout`, derives flags, and presents a tagged result over a second valid/ready handshake. One operation is in flight at a time, because the adder needs its operands held for the whole pass.

## Interface
- `LATENCY`, default 6: number of adder register stages between operand change and a settled `add_out`.
- `TAG_W`, default 4: width of the request tag.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts the request this edge.
- `req_op` in 1: 0 = add, 1 = subtract.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `req_cin` in 1: carry-in; add only, ignored on subtract.
- `req_tag` in TAG_W: opaque ID, returned with the result.
- `add_x` out 32: adder operand x.
- `add_y` out 32: adder operand y.
- `add_cin` out 1: adder carry-in.
- `add_out` in 32: adder sum.
- `add_cout` in 1: adder carry-out.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_sum` out 32: captured sum.
- `res_tag` out TAG_W: tag of the result.
- `res_carry` out 1: flag.
- `res_zero` out 1: flag.
- `res_neg` out 1: flag.
- `res_ovf` out 1: flag.

## Operation
- **States and reset.** FSM states are IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- **Reset values.** All registered outputs (`add_x`, `add_y`, `add_cin`, `res_*`, counter) reset to 0. `req_ready` is 0 while `rst_n` = 0.
- **Ready.** `req_ready` = (state==IDLE) | (state==DONE & `res_ready`). This is combinational from `res_ready`.
- **Accept.** On the accept edge (`req_valid` & `req_ready`):
  - `add_x` ← `req_a`.
  - Add: `add_y` ← `req_b`, `add_cin` ← `req_cin`.
  - Subtract: `add_y` ← ~`req_b`, `add_cin` ← 1.
  - The tag, the op, and bit 31 of `add_x`/`add_y` are latched.
  - Counter ← `LATENCY`; state → RUN.
- **Operand hold.** `add_x`/`add_y`/`add_cin` keep their values until the next accept. They are never cleared outside reset.
- **RUN.** Counter decrements each edge. On the edge where counter == 0, capture into the result registers and go to DONE:
  - `res_sum` ← `add_out`.
  - `res_carry` ← `add_cout`. For subtract, 1 means no borrow.
  - `res_zero` ← (`add_out` == 0).
  - `res_neg` ← `add_out[31]`.
  - `res_ovf` ← (x31 == y31) & (`add_out[31]` != x31), using the effective (possibly inverted) y.
- **DONE.** `res_valid` = 1. All `res_*` outputs are held stable until `res_ready`.
  - `res_ready` without `req_valid`: → IDLE and `res_valid` drops.
  - `res_ready` with `req_valid`: the result is consumed and the new request is accepted on the same edge; → RUN and `res_valid` drops.
- **Ignored requests.** `req_valid` during RUN, or during DONE without `res_ready`, is not accepted (ready = 0). The requester must hold it.
- **Reset mid-operation.** Reset during RUN or DONE aborts the operation. There is no partial result; `res_valid` is 0 after that edge.

## Timing
- **Result latency.** With accept edge E0, the adder's final stage register settles at E0+`LATENCY`. Capture happens at E0+`LATENCY`+1, and `res_valid` is high from that edge. Default: 7 cycles accept-to-valid.
- **Throughput.** With `res_ready` tied high, one operation every `LATENCY`+2 = 8 cycles via the DONE→RUN overlap.
- **Combinational paths.** No combinational path from `req_*` to `res_*`. The only combinational path is `res_ready` → `req_ready`.
- **Counter width.** `$clog2(LATENCY+1)` bits. It never wraps: it is loaded only on accept and stops at 0.

## Structure
- **Shared package `alu_pkg`.** Holds:
  - `ALU_OP_ADD`=1'b0 and `ALU_OP_SUB`=1'b1.
  - `ADD_LATENCY`=6, which is the default source for `LATENCY`.
  - The state encoding constants IDLE/RUN/DONE.
- **Sub-module `alu_flags`.** Purely combinational. Takes sum, cout, x31, y31 and returns carry, zero, neg, ovf. It is instantiated once in front of the result registers and is reusable by later ALU stages.

## Test plan
- **Basic add.** add 5+7, cin 0, tag 3 → `res_sum`=12, `res_tag`=3, all flags 0; `res_valid` rises exactly 7 edges after accept.
- **Subtract to zero.** sub 0x10−0x10 → `add_y`=0xFFFFFFEF, `add_cin`=1; `res_sum`=0, zero=1, carry=1, ovf=0.
- **Signed overflow, then carry-out.**
  - add 0x7FFFFFFF+1 → 0x80000000, neg=1, ovf=1, carry=0.
  - add 0xFFFFFFFF+1 → 0, carry=1, zero=1, ovf=0.
- **Subtract with borrow.** sub 0−1 → 0xFFFFFFFF, carry=0, neg=1, ovf=0.
- **Backpressure and overlap.** Hold `res_ready`=0 for 10 cycles in DONE → `res_*` unchanged and `req_ready`=0. Then assert `res_ready` together with `req_valid` → result consumed and new request accepted on the same edge, with its `res_valid` 7 edges later.
- **Busy and reset mid-operation.**
  - `req_valid` pulsed in RUN → not accepted, operands unchanged.
  - `rst_n`=0 at cycle 3 of RUN → next edge: IDLE, `res_valid`=0, all outputs 0; `req_ready`=1 after release.
